mem_load_sequencer: RTL and testbench

- Parametrised load controller: on a start pulse, reads COUNT consecutive words from a synchronous-read RAM starting at base_addr.
- Presents each word on a valid/ready output stream; reports completion with a finished level and a done pulse.
- Sits between the network weight/genome RAMs and the neuron evaluation datapath. Generalises the single-shot start/finished load FSM with configurable read latency, word count, backpressure and abort.

---
 rtl/mem_load_sequencer_pkg.sv | 8 +
 rtl/mem_load_sequencer.sv | 92 +++++++++
 tb/tb_mem_load_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_load_sequencer_pkg.sv
// mem_load_sequencer_pkg: shared FSM state encodings for the load sequencer
package mem_load_sequencer_pkg;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] S_EMIT  = 2'd3;
endpackage

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: reads count words from a sync-read RAM and streams them out with valid/ready
module mem_load_sequencer
    import mem_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   finished,
    output logic                   done
);
    logic [STATE_W-1:0]     state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [3:0]             wait_q;

    assign mem_rd   = state_q == S_ISSUE;
    assign mem_addr = addr_q;
    assign finished = state_q == S_IDLE;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            // abort also suppresses a start presented in the same idle cycle
            if (abort) begin
                state_q   <= S_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q      <= base_addr;
                            remaining_q <= count;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        wait_q  <= 4'(READ_LATENCY);
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        wait_q <= wait_q - 4'd1;
                        if (wait_q == 4'd1) begin
                            out_data  <= mem_data;
                            out_valid <= 1'b1;
                            out_last  <= remaining_q == COUNT_WIDTH'(1);
                            state_q   <= S_EMIT;
                        end
                    end
                    default: if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        remaining_q <= remaining_q - COUNT_WIDTH'(1);
                        if (remaining_q == COUNT_WIDTH'(1)) begin
                            done    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            state_q <= S_ISSUE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_load_sequencer.sv
// tb_mem_load_sequencer: directed self-checking bench with latency-accurate RAM models
module tb_mem_load_sequencer;
    logic clock = 1'b0, resetn = 1'b0, start = 1'b0, start_s = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] count = '0;
    int checks = 0, failures = 0;

    logic mem_rd_2, out_valid_2, out_last_2, finished_2, done_2;
    logic [7:0] mem_addr_2;
    logic [15:0] mem_data_2, out_data_2;
    logic mem_rd_1, out_valid_1, out_last_1, finished_1, done_1;
    logic [7:0] mem_addr_1;
    logic [15:0] mem_data_1, out_data_1;
    logic mem_rd_15, out_valid_15, out_last_15, finished_15, done_15;
    logic [7:0] mem_addr_15;
    logic [15:0] mem_data_15, out_data_15;

    always #5 clock = ~clock;

    function automatic logic [15:0] ram(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    logic [15:0] p2 [2];
    logic [15:0] p1;
    logic [15:0] p15 [15];
    always @(posedge clock) begin
        p2[0] <= mem_rd_2 ? ram(mem_addr_2) : 16'hDEAD;
        p2[1] <= p2[0];
        p1 <= mem_rd_1 ? ram(mem_addr_1) : 16'hDEAD;
        p15[0] <= mem_rd_15 ? ram(mem_addr_15) : 16'hDEAD;
        for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
    end
    assign mem_data_2  = p2[1];
    assign mem_data_1  = p1;
    assign mem_data_15 = p15[14];

    mem_load_sequencer #(.READ_LATENCY(2)) u2 (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort), .base_addr(base_addr), .count(count),
        .mem_rd(mem_rd_2), .mem_addr(mem_addr_2), .mem_data(mem_data_2), .out_data(out_data_2),
        .out_valid(out_valid_2), .out_last(out_last_2), .out_ready(out_ready), .finished(finished_2), .done(done_2));
    mem_load_sequencer #(.READ_LATENCY(1)) u1 (
        .clock(clock), .resetn(resetn), .start(start_s), .abort(1'b0), .base_addr(base_addr), .count(count),
        .mem_rd(mem_rd_1), .mem_addr(mem_addr_1), .mem_data(mem_data_1), .out_data(out_data_1),
        .out_valid(out_valid_1), .out_last(out_last_1), .out_ready(out_ready), .finished(finished_1), .done(done_1));
    mem_load_sequencer #(.READ_LATENCY(15)) u15 (
        .clock(clock), .resetn(resetn), .start(start_s), .abort(1'b0), .base_addr(base_addr), .count(count),
        .mem_rd(mem_rd_15), .mem_addr(mem_addr_15), .mem_data(mem_data_15), .out_data(out_data_15),
        .out_valid(out_valid_15), .out_last(out_last_15), .out_ready(out_ready), .finished(finished_15), .done(done_15));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] c);
        base_addr = b;
        count = c;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (finished_2 !== 1'b1) begin failures++; $display("FAIL reset_finished got=%0h exp=1", finished_2); end
        checks++; if ({done_2, mem_rd_2, out_valid_2, out_last_2} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done_2, mem_rd_2, out_valid_2, out_last_2}); end
        checks++; if ({mem_addr_2, out_data_2} !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", {mem_addr_2, out_data_2}); end
        step(2);
        resetn = 1'b1;
        step(1);
        out_ready = 1'b0;
        pulse_start(8'h60, 9'd2);
        checks++; if (mem_rd_2 !== 1'b1) begin failures++; $display("FAIL midload_issue got=%0h exp=1", mem_rd_2); end
        step(3);
        checks++; if (out_valid_2 !== 1'b1) begin failures++; $display("FAIL midload_valid got=%0h exp=1", out_valid_2); end
        resetn = 1'b0;
        #1;
        checks++; if ({finished_2, out_valid_2, mem_rd_2} !== 3'b100) begin failures++; $display("FAIL async_reset got=%b exp=100", {finished_2, out_valid_2, mem_rd_2}); end
        step(1);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        pulse_start(8'h10, 9'd3);
        for (int w = 0; w < 3; w++) begin
            checks++; if ({mem_rd_2, mem_addr_2} !== {1'b1, 8'h10 + 8'(w)}) begin failures++; $display("FAIL basic_issue w=%0d got=%h exp=%h", w, {mem_rd_2, mem_addr_2}, {1'b1, 8'h10 + 8'(w)}); end
            step(1);
            checks++; if (mem_rd_2 !== 1'b0) begin failures++; $display("FAIL basic_rd_low w=%0d got=%0h exp=0", w, mem_rd_2); end
            step(2);
            checks++; if ({out_valid_2, out_last_2, finished_2} !== {2'b1_0 | {1'b0, w == 2}, 1'b0}) begin failures++; $display("FAIL basic_flags w=%0d got=%b exp=%b", w, {out_valid_2, out_last_2, finished_2}, {1'b1, w == 2, 1'b0}); end
            checks++; if (out_data_2 !== ram(8'h10 + 8'(w))) begin failures++; $display("FAIL basic_data w=%0d got=%h exp=%h", w, out_data_2, ram(8'h10 + 8'(w))); end
            step(1);
        end
        checks++; if ({done_2, finished_2, out_valid_2} !== 3'b110) begin failures++; $display("FAIL basic_done got=%b exp=110", {done_2, finished_2, out_valid_2}); end
        step(1);
        checks++; if (done_2 !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0h exp=0", done_2); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        pulse_start(8'h20, 9'd2);
        step(3);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if ({out_valid_2, mem_rd_2, out_data_2} !== {2'b10, ram(8'h20)}) begin failures++; $display("FAIL bp_hold i=%0d got=%h exp=%h", i, {out_valid_2, mem_rd_2, out_data_2}, {2'b10, ram(8'h20)}); end
        end
        out_ready = 1'b1;
        step(1);
        checks++; if ({out_valid_2, mem_rd_2, mem_addr_2} !== {2'b01, 8'h21}) begin failures++; $display("FAIL bp_next got=%h exp=%h", {out_valid_2, mem_rd_2, mem_addr_2}, {2'b01, 8'h21}); end
        step(3);
        checks++; if ({out_valid_2, out_last_2, out_data_2} !== {2'b11, ram(8'h21)}) begin failures++; $display("FAIL bp_word2 got=%h exp=%h", {out_valid_2, out_last_2, out_data_2}, {2'b11, ram(8'h21)}); end
        step(1);
        checks++; if (done_2 !== 1'b1) begin failures++; $display("FAIL bp_done got=%0h exp=1", done_2); end
        step(1);
    endtask

    task automatic test_wrap;
        logic [7:0] a;
        out_ready = 1'b1;
        pulse_start(8'hFE, 9'd3);
        for (int w = 0; w < 3; w++) begin
            a = 8'hFE + 8'(w);
            checks++; if ({mem_rd_2, mem_addr_2} !== {1'b1, a}) begin failures++; $display("FAIL wrap_addr w=%0d got=%h exp=%h", w, {mem_rd_2, mem_addr_2}, {1'b1, a}); end
            step(3);
            checks++; if ({out_last_2, out_data_2} !== {w == 2, ram(a)}) begin failures++; $display("FAIL wrap_data w=%0d got=%h exp=%h", w, {out_last_2, out_data_2}, {w == 2, ram(a)}); end
            step(1);
        end
        checks++; if (done_2 !== 1'b1) begin failures++; $display("FAIL wrap_done got=%0h exp=1", done_2); end
        step(1);
    endtask

    task automatic test_zero_count;
        pulse_start(8'h33, 9'd0);
        checks++; if ({done_2, finished_2, mem_rd_2} !== 3'b110) begin failures++; $display("FAIL zero_done got=%b exp=110", {done_2, finished_2, mem_rd_2}); end
        step(1);
        checks++; if ({done_2, mem_rd_2} !== 2'b00) begin failures++; $display("FAIL zero_after got=%b exp=00", {done_2, mem_rd_2}); end
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        pulse_start(8'h40, 9'd4);
        step(4);
        checks++; if ({mem_rd_2, mem_addr_2} !== {1'b1, 8'h41}) begin failures++; $display("FAIL abort_word2 got=%h exp=%h", {mem_rd_2, mem_addr_2}, {1'b1, 8'h41}); end
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++; if ({finished_2, out_valid_2, mem_rd_2, done_2} !== 4'b1000) begin failures++; $display("FAIL abort_idle got=%b exp=1000", {finished_2, out_valid_2, mem_rd_2, done_2}); end
        step(3);
        checks++; if ({done_2, out_valid_2} !== 2'b00) begin failures++; $display("FAIL abort_no_done got=%b exp=00", {done_2, out_valid_2}); end
        abort = 1'b1;
        pulse_start(8'h70, 9'd1);
        abort = 1'b0;
        checks++; if ({finished_2, mem_rd_2} !== 2'b10) begin failures++; $display("FAIL abort_vs_start got=%b exp=10", {finished_2, mem_rd_2}); end
        pulse_start(8'h50, 9'd1);
        checks++; if ({mem_rd_2, mem_addr_2} !== {1'b1, 8'h50}) begin failures++; $display("FAIL abort_restart got=%h exp=%h", {mem_rd_2, mem_addr_2}, {1'b1, 8'h50}); end
        step(3);
        checks++; if ({out_valid_2, out_last_2, out_data_2} !== {2'b11, ram(8'h50)}) begin failures++; $display("FAIL abort_restart_data got=%h exp=%h", {out_valid_2, out_last_2, out_data_2}, {2'b11, ram(8'h50)}); end
        step(1);
        checks++; if (done_2 !== 1'b1) begin failures++; $display("FAIL abort_restart_done got=%0h exp=1", done_2); end
        step(1);
    endtask

    task automatic test_latency;
        int lat1 = -1, lat15 = -1;
        logic [15:0] d1 = '0, d15 = '0;
        out_ready = 1'b1;
        base_addr = 8'h30;
        count = 9'd1;
        start_s = 1'b1;
        step(1);
        start_s = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (out_valid_1 && lat1 < 0) begin lat1 = n; d1 = out_data_1; end
            if (out_valid_15 && lat15 < 0) begin lat15 = n; d15 = out_data_15; end
            step(1);
        end
        checks++; if (lat1 != 3) begin failures++; $display("FAIL lat1_cycles got=%0d exp=3", lat1); end
        checks++; if (lat15 != 17) begin failures++; $display("FAIL lat15_cycles got=%0d exp=17", lat15); end
        checks++; if ({d1, d15} !== {ram(8'h30), ram(8'h30)}) begin failures++; $display("FAIL lat_data got=%h exp=%h", {d1, d15}, {ram(8'h30), ram(8'h30)}); end
        checks++; if ({finished_1, finished_15} !== 2'b11) begin failures++; $display("FAIL lat_finished got=%b exp=11", {finished_1, finished_15}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_zero_count;
        test_abort;
        test_latency;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
